dpram_port_arbiter: RTL and testbench



---
 rtl/dpram_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_dpram_port_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter
//
// Round-robin arbiter sharing one dual-port RAM between NUM_REQ requesters.
// Each cycle up to two pending requests are granted, one per RAM port, and
// the RAM address/data/write-enable lines are driven in the same cycle.
// Read data returns to the owning requester one cycle after the grant.
//
// Optional feature macro: DPRAM_ARB_COLLISION_CHECK_EN
//   When defined, the second candidate (port 2) is withheld if it targets
//   the same address as the port-1 winner and either of them is a write.
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset      in   synchronous, active-high reset
//   req_valid  in   [NUM_REQ]             request pending per requester
//   req_we     in   [NUM_REQ]             1 = write, 0 = read
//   req_addr   in   [NUM_REQ*ADDR_WIDTH]  packed per requester
//   req_wdata  in   [NUM_REQ*DATA_WIDTH]  packed per requester
//   req_ready  out  [NUM_REQ]             combinational grant
//   rsp_valid  out  [NUM_REQ]             read data valid
//   rsp_data   out  [NUM_REQ*DATA_WIDTH]  read data, packed per requester
//   ram_we1/2, ram_addr1/2, ram_data1/2   out  RAM port drive
//   ram_out1/2 in   RAM read data (registered in RAM, 1-cycle latency)

module dpram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data,
  output logic                          ram_we1,
  output logic                          ram_we2,
  output logic [ADDR_WIDTH-1:0]         ram_addr1,
  output logic [ADDR_WIDTH-1:0]         ram_addr2,
  output logic [DATA_WIDTH-1:0]         ram_data1,
  output logic [DATA_WIDTH-1:0]         ram_data2,
  input  logic [DATA_WIDTH-1:0]         ram_out1,
  input  logic [DATA_WIDTH-1:0]         ram_out2
);

  localparam int PW = $clog2(NUM_REQ);

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] rsp_arr   [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign addr_arr[k]  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[k] = req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
    assign rsp_data[k*DATA_WIDTH +: DATA_WIDTH] = rsp_arr[k];
  end

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic          found_a;
  logic          found_b;
  logic [PW-1:0] idx_a;
  logic [PW-1:0] idx_b;
  logic          collide;
  logic          grant_a;
  logic          grant_b;

  logic          tag_v1;
  logic          tag_v2;
  logic [PW-1:0] tag_idx1;
  logic [PW-1:0] tag_idx2;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    if (int'(v) >= NUM_REQ - 1) return '0;
    else                        return v + 1'b1;
  endfunction

  // Scan ptr, ptr+1, ... mod NUM_REQ; first valid is A, second is B.
  // A requester appears once in the scan, so it can never win both ports.
  always_comb begin
    int            j;
    logic [PW-1:0] jj;
    found_a = 1'b0;
    found_b = 1'b0;
    idx_a   = '0;
    idx_b   = '0;
    j       = 0;
    jj      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = PW'(j);
      if (req_valid[jj]) begin
        if (!found_a) begin
          found_a = 1'b1;
          idx_a   = jj;
        end else if (!found_b) begin
          found_b = 1'b1;
          idx_b   = jj;
        end
      end
    end
  end

`ifdef DPRAM_ARB_COLLISION_CHECK_EN
  // Two reads of one address are harmless; anything involving a write is not.
  assign collide = found_a && found_b &&
                   (addr_arr[idx_a] == addr_arr[idx_b]) &&
                   (req_we[idx_a] || req_we[idx_b]);
`else
  assign collide = 1'b0;
`endif

  // Reset suppresses all grants so nothing reaches the RAM while it is held.
  assign grant_a = found_a && !reset;
  assign grant_b = found_b && !collide && !reset;

  always_comb begin
    req_ready = '0;
    if (grant_a) req_ready[idx_a] = 1'b1;
    if (grant_b) req_ready[idx_b] = 1'b1;
  end

  always_comb begin
    ram_we1   = 1'b0;
    ram_addr1 = '0;
    ram_data1 = '0;
    ram_we2   = 1'b0;
    ram_addr2 = '0;
    ram_data2 = '0;
    if (grant_a) begin
      ram_we1   = req_we[idx_a];
      ram_addr1 = addr_arr[idx_a];
      ram_data1 = wdata_arr[idx_a];
    end
    if (grant_b) begin
      ram_we2   = req_we[idx_b];
      ram_addr2 = addr_arr[idx_b];
      ram_data2 = wdata_arr[idx_b];
    end
  end

  always_comb begin
    ptr_next = ptr;
    if (grant_b)      ptr_next = wrap_inc(idx_b);
    else if (grant_a) ptr_next = wrap_inc(idx_a);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      tag_v1   <= 1'b0;
      tag_v2   <= 1'b0;
      tag_idx1 <= '0;
      tag_idx2 <= '0;
    end else begin
      ptr      <= ptr_next;
      tag_v1   <= grant_a && !req_we[idx_a];
      tag_v2   <= grant_b && !req_we[idx_b];
      tag_idx1 <= idx_a;
      tag_idx2 <= idx_b;
    end
  end

  // The tags are still set during the first reset cycle; gating with reset
  // drops the response of a read granted just before reset asserted.
  always_comb begin
    rsp_valid = '0;
    for (int k = 0; k < NUM_REQ; k++) rsp_arr[k] = '0;
    if (tag_v1 && !reset) begin
      rsp_valid[tag_idx1] = 1'b1;
      rsp_arr[tag_idx1]   = ram_out1;
    end
    if (tag_v2 && !reset) begin
      rsp_valid[tag_idx2] = 1'b1;
      rsp_arr[tag_idx2]   = ram_out2;
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
module tb_dpram_port_arbiter;

  localparam int NR = 4;
  localparam int AW = 11;
  localparam int DW = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_we;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [NR*DW-1:0]  rsp_data;
  logic              ram_we1, ram_we2;
  logic [AW-1:0]     ram_addr1, ram_addr2;
  logic [DW-1:0]     ram_data1, ram_data2;
  logic [DW-1:0]     ram_out1, ram_out2;

  int compared = 0;
  int failed   = 0;

  dpram_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_we1(ram_we1), .ram_we2(ram_we2),
    .ram_addr1(ram_addr1), .ram_addr2(ram_addr2),
    .ram_data1(ram_data1), .ram_data2(ram_data2),
    .ram_out1(ram_out1), .ram_out2(ram_out2)
  );

  always #5 clk = ~clk;

  // Behavioural dual-port RAM: registered read, read-during-write returns old data.
  logic [DW-1:0] mem [1<<AW];
  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    ram_out1 = '0;
    ram_out2 = '0;
  end
  always @(posedge clk) begin
    ram_out1 <= mem[ram_addr1];
    ram_out2 <= mem[ram_addr2];
    if (ram_we1) mem[ram_addr1] <= ram_data1;
    if (ram_we2) mem[ram_addr2] <= ram_data2;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[k]           = 1'b1;
    req_we[k]              = we;
    req_addr[k*AW +: AW]   = a;
    req_wdata[k*DW +: DW]  = d;
  endtask

  task automatic reset_dut;
    tick;
    reset = 1'b1;
    clear_reqs;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clear_reqs;
    for (int k = 0; k < NR; k++) set_req(k, 1'b0, AW'(k + 1), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++;
    if (req_ready !== 4'b0000) begin failed++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
    compared++;
    if ({ram_we1, ram_we2} !== 2'b00) begin failed++; $display("FAIL rst_we got=%b exp=00", {ram_we1, ram_we2}); end
    compared++;
    if ({ram_addr1, ram_addr2} !== '0) begin failed++; $display("FAIL rst_addr got=%h/%h exp=0/0", ram_addr1, ram_addr2); end
    tick;
    reset = 1'b0;
    clear_reqs;
    @(negedge clk);
    compared++;
    if (rsp_valid !== 4'b0000) begin failed++; $display("FAIL rst_rsp_valid got=%b exp=0000", rsp_valid); end
    compared++;
    if (rsp_data !== 4'b0000) begin failed++; $display("FAIL rst_rsp_data got=%b exp=0000", rsp_data); end
  endtask

  task automatic test_write_read;
    tick;
    clear_reqs;
    set_req(1, 1'b1, 11'h0A5, 1'b1);
    @(negedge clk);
    compared++;
    if (req_ready !== 4'b0010) begin failed++; $display("FAIL wr_ready got=%b exp=0010", req_ready); end
    compared++;
    if ({ram_we1, ram_addr1, ram_data1, ram_we2} !== {1'b1, 11'h0A5, 1'b1, 1'b0})
      begin failed++; $display("FAIL wr_port got=%b/%h/%b/%b exp=1/0a5/1/0", ram_we1, ram_addr1, ram_data1, ram_we2); end
    tick;
    clear_reqs;
    set_req(1, 1'b0, 11'h0A5, 1'b0);
    @(negedge clk);
    compared++;
    if ({req_ready, ram_we1} !== {4'b0010, 1'b0}) begin failed++; $display("FAIL rd_grant got=%b/%b exp=0010/0", req_ready, ram_we1); end
    compared++;
    if (rsp_valid !== 4'b0000) begin failed++; $display("FAIL wr_no_rsp got=%b exp=0000", rsp_valid); end
    tick;
    clear_reqs;
    @(negedge clk);
    compared++;
    if (rsp_valid !== 4'b0010) begin failed++; $display("FAIL rd_rsp_valid got=%b exp=0010", rsp_valid); end
    compared++;
    if (rsp_data !== 4'b0010) begin failed++; $display("FAIL rd_rsp_data got=%b exp=0010", rsp_data); end
  endtask

  task automatic test_round_robin;
    logic [NR-1:0] exp_ready [3];
    logic [NR-1:0] exp_rsp   [4];
    logic [NR-1:0] exp_data  [4];
    exp_ready = '{4'b0011, 4'b1100, 4'b0011};
    exp_rsp   = '{4'b0000, 4'b0011, 4'b1100, 4'b0011};
    exp_data  = '{4'b0000, 4'b0000, 4'b0100, 4'b0000};
    reset_dut;
    clear_reqs;
    set_req(0, 1'b0, 11'h001, '0);
    set_req(1, 1'b0, 11'h002, '0);
    set_req(2, 1'b0, 11'h0A5, '0);
    set_req(3, 1'b0, 11'h003, '0);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) clear_reqs;
      @(negedge clk);
      if (c < 3) begin
        compared++;
        if (req_ready !== exp_ready[c]) begin failed++; $display("FAIL rr_ready[%0d] got=%b exp=%b", c, req_ready, exp_ready[c]); end
      end
      if (c == 0) begin
        compared++;
        if ({ram_addr1, ram_addr2} !== {11'h001, 11'h002})
          begin failed++; $display("FAIL rr_addr got=%h/%h exp=001/002", ram_addr1, ram_addr2); end
      end
      compared++;
      if (rsp_valid !== exp_rsp[c]) begin failed++; $display("FAIL rr_rsp_valid[%0d] got=%b exp=%b", c, rsp_valid, exp_rsp[c]); end
      compared++;
      if (rsp_data !== exp_data[c]) begin failed++; $display("FAIL rr_rsp_data[%0d] got=%b exp=%b", c, rsp_data, exp_data[c]); end
      tick;
    end
    clear_reqs;
  endtask

  task automatic test_single;
    reset_dut;
    clear_reqs;
    set_req(2, 1'b0, 11'h123, '0);
    @(negedge clk);
    compared++;
    if (req_ready !== 4'b0100) begin failed++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    compared++;
    if ({ram_addr1, ram_we2} !== {11'h123, 1'b0}) begin failed++; $display("FAIL single_port got=%h/%b exp=123/0", ram_addr1, ram_we2); end
    tick;
    clear_reqs;
    for (int k = 0; k < NR; k++) set_req(k, 1'b0, 11'h004, '0);
    @(negedge clk);
    compared++;
    if (req_ready !== 4'b1001) begin failed++; $display("FAIL single_ptr_next got=%b exp=1001", req_ready); end
    tick;
    clear_reqs;
  endtask

  task automatic test_reset_midop;
    reset_dut;
    clear_reqs;
    set_req(0, 1'b0, 11'h0A5, '0);
    @(negedge clk);
    compared++;
    if (req_ready !== 4'b0001) begin failed++; $display("FAIL mid_grant got=%b exp=0001", req_ready); end
    tick;
    reset = 1'b1;
    clear_reqs;
    @(negedge clk);
    compared++;
    if (rsp_valid !== 4'b0000) begin failed++; $display("FAIL mid_rsp_in_reset got=%b exp=0000", rsp_valid); end
    tick;
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (rsp_valid !== 4'b0000) begin failed++; $display("FAIL mid_rsp_after got=%b exp=0000", rsp_valid); end
  endtask

  task automatic test_collision;
    reset_dut;
    clear_reqs;
    set_req(0, 1'b1, 11'h010, 1'b0);
    set_req(1, 1'b1, 11'h010, 1'b1);
    @(negedge clk);
`ifdef DPRAM_ARB_COLLISION_CHECK_EN
    compared++;
    if ({req_ready, ram_we2} !== {4'b0001, 1'b0}) begin failed++; $display("FAIL coll_first got=%b/%b exp=0001/0", req_ready, ram_we2); end
    tick;
    clear_reqs;
    set_req(1, 1'b1, 11'h010, 1'b1);
    @(negedge clk);
    compared++;
    if ({req_ready, ram_we1, ram_addr1} !== {4'b0010, 1'b1, 11'h010})
      begin failed++; $display("FAIL coll_second got=%b/%b/%h exp=0010/1/010", req_ready, ram_we1, ram_addr1); end
    tick;
    clear_reqs;
    set_req(2, 1'b0, 11'h010, '0);
    @(negedge clk);
    compared++;
    if (req_ready !== 4'b0100) begin failed++; $display("FAIL coll_rd_grant got=%b exp=0100", req_ready); end
    tick;
    clear_reqs;
    @(negedge clk);
    compared++;
    if ({rsp_valid, rsp_data} !== {4'b0100, 4'b0100})
      begin failed++; $display("FAIL coll_rd_data got=%b/%b exp=0100/0100", rsp_valid, rsp_data); end
`else
    compared++;
    if ({req_ready, ram_we1, ram_we2} !== {4'b0011, 1'b1, 1'b1})
      begin failed++; $display("FAIL coll_both got=%b/%b/%b exp=0011/1/1", req_ready, ram_we1, ram_we2); end
    tick;
    clear_reqs;
`endif
  endtask

  initial begin
    clear_reqs;
    reset = 1'b1;
    test_reset;
    test_write_read;
    test_round_robin;
    test_single;
    test_reset_midop;
    test_collision;
    repeat (2) tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
